// File: rtl/minmax_nch.sv
// N-channel extremum acquirer: starts all enabled ADCs with one soc, waits for every
// enabled eoc, then offers the min/max sample and its channel index over dav_/rfd.
module minmax_nch #(
  parameter int W = 8,
  parameter int N = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N-1:0]           eoc,
  input  logic [N*W-1:0]         x,
  input  logic [N-1:0]           en,
  input  logic                   mode,
  input  logic                   rfd,
  output logic                   soc,
  output logic                   dav_,
  output logic [W-1:0]           result,
  output logic [$clog2(N)-1:0]   idx
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  state_t         state;
  logic [N-1:0]   en_r;
  logic           mode_r;

  logic [N-1:0]   mask;
  logic           all_clear;
  logic           all_done;
  logic [W-1:0]   ext;
  logic [IW-1:0]  arg_ext;
  logic [W-1:0]   sample;
  logic           found;

  // An all-zero enable mask would leave nothing to reduce, so it means "every channel".
  assign mask      = (en == '0) ? '1 : en;
  assign all_clear = ((eoc & mask) == '0);
  assign all_done  = ((eoc & en_r) == en_r);

  // Scanning upward and replacing only on a strict improvement makes the
  // lowest-index channel win every tie.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    ext     = '0;
    arg_ext = '0;
    sample  = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (en_r[i]) begin
        sample = x[i*W +: W];
        if (!found || (mode_r ? (sample > ext) : (sample < ext))) begin
          ext     = sample;
          arg_ext = IW'(i);
          found   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state  <= S0;
      soc    <= 1'b0;
      dav_   <= 1'b1;
      result <= '0;
      idx    <= '0;
      en_r   <= '1;
      mode_r <= 1'b0;
    end else begin
      case (state)
        S0: begin
          soc    <= 1'b1;
          en_r   <= mask;
          mode_r <= mode;
          if (all_clear) state <= S1;
        end
        S1: begin
          soc <= 1'b0;
          if (all_done) begin
            result <= ext;
            idx    <= arg_ext;
            state  <= S2;
          end
        end
        S2: begin
          dav_ <= 1'b0;
          if (!rfd) state <= S3;
        end
        S3: begin
          dav_ <= 1'b1;
          if (rfd) state <= S0;
        end
        default: state <= S0;
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_nch.sv
// Self-checking bench for minmax_nch (W=8, N=3): expected extrema are queued when the
// ADC samples are driven and compared when dav_ falls.
module tb_minmax_nch;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int IW = $clog2(N);

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     eoc;
  logic [N*W-1:0]   x;
  logic [N-1:0]     en;
  logic             mode;
  logic             rfd;
  logic             soc;
  logic             dav_;
  logic [W-1:0]     result;
  logic [IW-1:0]    idx;

  typedef struct {
    logic [W-1:0]  r;
    logic [IW-1:0] i;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  minmax_nch #(.W(W), .N(N)) dut (
    .clock (clock),
    .reset (reset),
    .eoc   (eoc),
    .x     (x),
    .en    (en),
    .mode  (mode),
    .rfd   (rfd),
    .soc   (soc),
    .dav_  (dav_),
    .result(result),
    .idx   (idx)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [N*W-1:0] pack3(input int c0, input int c1, input int c2);
    return {W'(c2), W'(c1), W'(c0)};
  endfunction

  // Reference: find the extreme value first, then the lowest enabled channel holding it.
  function automatic exp_t model(input logic [N*W-1:0] xv, input logic [N-1:0] e, input bit md);
    exp_t         r;
    logic [N-1:0] m;
    int           best;
    int           v;
    m    = (e == '0) ? '1 : e;
    best = md ? -1 : (1 << W);
    for (int i = 0; i < N; i++) begin
      v = int'(xv[i*W +: W]);
      if (m[i] && (md ? (v > best) : (v < best))) best = v;
    end
    r.r = W'(best);
    r.i = '0;
    for (int i = N - 1; i >= 0; i--)
      if (m[i] && int'(xv[i*W +: W]) == best) r.i = IW'(i);
    return r;
  endfunction

  task automatic wait_dav_low(input string tag);
    int   cycles;
    exp_t e;
    cycles = 0;
    while (dav_ !== 1'b0 && cycles < 20) begin
      tick();
      cycles++;
    end
    if (dav_ !== 1'b0) begin
      check({tag, "_dav_timeout"}, dav_, 0);
      return;
    end
    check({tag, "_latency"}, cycles, 2);
    check({tag, "_soc_low"}, soc, 0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_result"}, result, e.r);
    check({tag, "_idx"}, idx, e.i);
  endtask

  // Starts an acquisition from S3/S0, raises eocv once soc is seen, checks the result.
  task automatic acquire(input string tag, input logic [N*W-1:0] xv, input logic [N-1:0] env,
                         input bit md, input logic [N-1:0] eocv);
    int cycles;
    eoc  = '0;
    x    = xv;
    en   = env;
    mode = md;
    cycles = 0;
    while (soc !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    if (soc !== 1'b1) begin
      check({tag, "_soc_timeout"}, soc, 1);
      return;
    end
    eoc = eocv;
    sb.push_back(model(xv, env, md));
    wait_dav_low(tag);
  endtask

  task automatic handshake(input string tag);
    int cycles;
    rfd = 1'b0;
    cycles = 0;
    while (dav_ !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    check({tag, "_dav_release"}, dav_, 1);
    rfd = 1'b1;
  endtask

  initial begin
    logic [W-1:0]  hold_r;
    logic [IW-1:0] hold_i;

    reset = 1'b1;
    eoc   = '0;
    x     = '0;
    en    = '1;
    mode  = 1'b0;
    rfd   = 1'b1;
    tick();
    tick();
    check("rst_soc", soc, 0);
    check("rst_dav", dav_, 1);
    check("rst_result", result, 0);
    check("rst_idx", idx, 0);
    reset = 1'b0;

    // Minimum over all three channels, then hold dav_ with rfd=1.
    acquire("min3", pack3(30, 12, 200), 3'b111, 1'b0, 3'b111);
    hold_r = result;
    hold_i = idx;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_dav", dav_, 0);
      check("hold_result", result, hold_r);
      check("hold_idx", idx, hold_i);
    end
    eoc = '0;
    rfd = 1'b0;
    tick();
    check("s3_entry_dav", dav_, 0);
    tick();
    check("s3_dav_high", dav_, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rfd_low_no_soc", soc, 0);
    end
    rfd = 1'b1;

    // Maximum with channel 1 disabled and its eoc never asserted.
    acquire("max_en101", pack3(30, 250, 200), 3'b101, 1'b1, 3'b101);
    handshake("max_en101");

    acquire("tie_min", pack3(7, 7, 9), 3'b111, 1'b0, 3'b111);
    handshake("tie_min");

    acquire("en000_min", pack3(50, 20, 20), 3'b000, 1'b0, 3'b111);
    handshake("en000_min");

    acquire("en000_max", pack3(3, 40, 255), 3'b000, 1'b1, 3'b111);
    handshake("en000_max");

    acquire("single_ch1", pack3(1, 99, 0), 3'b010, 1'b0, 3'b010);
    handshake("single_ch1");

    // Reset held for two cycles while the result is on offer in S2.
    acquire("pre_reset", pack3(90, 80, 70), 3'b111, 1'b1, 3'b111);
    reset = 1'b1;
    tick();
    check("mid_rst1_dav", dav_, 1);
    tick();
    check("mid_rst_soc", soc, 0);
    check("mid_rst_dav", dav_, 1);
    check("mid_rst_result", result, 0);
    check("mid_rst_idx", idx, 0);
    reset = 1'b0;
    acquire("post_reset", pack3(4, 8, 2), 3'b111, 1'b0, 3'b111);
    handshake("post_reset");

    // eoc still high in S0 keeps soc asserted without advancing; mode flips during S1.
    eoc  = 3'b111;
    en   = 3'b111;
    mode = 1'b0;
    x    = pack3(5, 100, 50);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stuck_eoc_soc", soc, 1);
      check("stuck_eoc_dav", dav_, 1);
    end
    eoc = '0;
    tick();
    mode = 1'b1;
    en   = 3'b010;
    eoc  = 3'b111;
    sb.push_back(model(pack3(5, 100, 50), 3'b111, 1'b0));
    wait_dav_low("mode_toggle");
    handshake("mode_toggle");

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
